// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register target: FSM states, ACK/NACK bit levels
// and a 3-input majority helper used by the optional line glitch filter.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WACK,
        RDATA,
        RACK
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes the raw SCL/SDA pins and emits one-clk SCL-edge, START and STOP pulses.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter (2 clk extra latency).
import i2c_pkg::*;

module i2c_bus_monitor (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_lvl
);

    logic [1:0] scl_sync_q, scl_sync_d;
    logic [1:0] sda_sync_q, sda_sync_d;
    logic       scl_line, sda_line;
    logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
    logic       scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
    logic       start_q, start_d, stop_q, stop_d;

    always_comb begin
        scl_sync_d = {scl_sync_q[0], scl_i};
        sda_sync_d = {sda_sync_q[0], sda_i};
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
    logic       scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;

    always_comb begin
        scl_hist_d = {scl_hist_q[0], scl_sync_q[1]};
        sda_hist_d = {sda_hist_q[0], sda_sync_q[1]};
        scl_filt_d = maj3(scl_sync_q[1], scl_hist_q[0], scl_hist_q[1]);
        sda_filt_d = maj3(sda_sync_q[1], sda_hist_q[0], sda_hist_q[1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
        end
    end

    assign scl_line = scl_filt_q;
    assign sda_line = sda_filt_q;
`else
    assign scl_line = scl_sync_q[1];
    assign sda_line = sda_sync_q[1];
`endif

    // START/STOP need SCL high on both the previous and current sample.
    always_comb begin
        scl_prev_d = scl_line;
        sda_prev_d = sda_line;
        scl_rise_d = scl_line & ~scl_prev_q;
        scl_fall_d = ~scl_line & scl_prev_q;
        start_d    = scl_line & scl_prev_q & sda_prev_q & ~sda_line;
        stop_d     = scl_line & scl_prev_q & ~sda_prev_q & sda_line;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            scl_rise_q <= 1'b0;
            scl_fall_q <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
            scl_rise_q <= scl_rise_d;
            scl_fall_q <= scl_fall_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
        end
    end

    assign scl_rise  = scl_rise_q;
    assign scl_fall  = scl_fall_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign sda_lvl   = sda_prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing NREGS 8-bit registers with an auto-incrementing pointer.
// Optional glitch filter in i2c_bus_monitor is enabled by I2C_TARGET_GLITCH_FILTER_EN.
import i2c_pkg::*;

module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR  = 7'h10,
    parameter int         NREGS     = 32,
    parameter logic [7:0] RESET_VAL = 8'h00,
    localparam int        AW        = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scl_i,
    input  logic          sda_i,
    output logic          sda_oe,
    output logic          reg_wr_stb,
    output logic [AW-1:0] reg_wr_addr,
    output logic [7:0]    reg_wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_lvl;

    i2c_bus_monitor u_bus_monitor (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_lvl   (sda_lvl)
    );

    i2c_state_t    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    tx_q, tx_d;
    logic [AW-1:0] ptr_q, ptr_d, ptr_inc;
    logic          sda_oe_q, sda_oe_d;
    logic          wr_stb_q, wr_stb_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [NREGS];
    logic [7:0]    regs_d [NREGS];
    logic          byte_done;

    assign ptr_inc   = ptr_q + AW'(1);
    assign byte_done = (bit_cnt_q == 4'd8);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            rx_q      <= 8'h00;
            tx_q      <= 8'h00;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            regs_q    <= regs_d;
        end
    end

    // Byte and ACK boundaries are taken on SCL falling edges so SDA only moves while SCL is low.
    always_comb begin
        state_d = state_q;
        if (stop_det) begin
            state_d = IDLE;
        end else if (start_det) begin
            state_d = ADDR;
        end else if (scl_fall) begin
            case (state_q)
                ADDR:     if (byte_done) state_d = (rx_q[7:1] == DEV_ADDR) ? ADDR_ACK : IDLE;
                ADDR_ACK: state_d = rx_q[0] ? RDATA : PTR;
                PTR:      if (byte_done) state_d = PTR_ACK;
                PTR_ACK:  state_d = WDATA;
                WDATA:    if (byte_done) state_d = WACK;
                WACK:     state_d = WDATA;
                RDATA:    if (byte_done) state_d = RACK;
                RACK:     state_d = (rx_q[0] == I2C_ACK) ? RDATA : IDLE;
                default:  state_d = state_q;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (stop_det || start_det) begin
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (scl_rise) begin
            if ((state_q == ADDR || state_q == PTR || state_q == WDATA || state_q == RDATA)
                && !byte_done) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
                rx_d      = {rx_q[6:0], sda_lvl};
            end else if (state_q == RACK) begin
                rx_d = {rx_q[6:0], sda_lvl};
            end
        end else if (scl_fall) begin
            case (state_q)
                ADDR: if (byte_done) begin
                    bit_cnt_d = 4'd0;
                    sda_oe_d  = (rx_q[7:1] == DEV_ADDR);
                end
                ADDR_ACK: begin
                    tx_d     = regs_q[ptr_q];
                    sda_oe_d = rx_q[0] & ~regs_q[ptr_q][7];
                end
                PTR: if (byte_done) begin
                    bit_cnt_d = 4'd0;
                    ptr_d     = rx_q[AW-1:0];
                    sda_oe_d  = 1'b1;
                end
                WDATA: if (byte_done) begin
                    bit_cnt_d = 4'd0;
                    wr_stb_d  = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = rx_q;
                    ptr_d     = ptr_inc;
                    sda_oe_d  = 1'b1;
                end
                PTR_ACK, WACK: sda_oe_d = 1'b0;
                RDATA: begin
                    if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        sda_oe_d  = 1'b0;
                    end else if (bit_cnt_q != 4'd0) begin
                        tx_d     = {tx_q[6:0], 1'b0};
                        sda_oe_d = ~tx_q[6];
                    end
                end
                RACK: begin
                    if (rx_q[0] == I2C_NACK) begin
                        sda_oe_d = 1'b0;
                    end else begin
                        ptr_d    = ptr_inc;
                        tx_d     = regs_q[ptr_inc];
                        sda_oe_d = ~regs_q[ptr_inc][7];
                    end
                end
                default: sda_oe_d = 1'b0;
            endcase
        end
    end

    // The array is written the cycle after the strobe, so a same-cycle fabric read sees the old value.
    always_comb begin
        regs_d = regs_q;
        if (wr_stb_q) regs_d[wr_addr_q] = wr_data_q;
    end

    assign sda_oe      = sda_oe_q;
    assign reg_wr_stb  = wr_stb_q;
    assign reg_wr_addr = wr_addr_q;
    assign reg_wr_data = wr_data_q;
    assign rd_data     = regs_q[rd_addr];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C controller drives the bus, a strobe monitor
// checks register writes against an expected queue. The glitch case needs I2C_TARGET_GLITCH_FILTER_EN.
module tb_i2c_target_regs;

    localparam int Q = 10;

    logic       clk;
    logic       rst_n;
    logic       scl_i;
    logic       sda_ctrl;
    logic       sda_line;
    logic       sda_oe;
    logic       reg_wr_stb;
    logic [4:0] reg_wr_addr;
    logic [7:0] reg_wr_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;

    assign sda_line = sda_ctrl & ~sda_oe;

    i2c_target_regs #(
        .DEV_ADDR  (7'h10),
        .NREGS     (32),
        .RESET_VAL (8'h00)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_i       (scl_i),
        .sda_i       (sda_line),
        .sda_oe      (sda_oe),
        .reg_wr_stb  (reg_wr_stb),
        .reg_wr_addr (reg_wr_addr),
        .reg_wr_data (reg_wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    logic [12:0] exp_q[$];
    logic [7:0]  mdl [32];
    logic        chk_pend;
    logic [7:0]  chk_val;
    logic        prev_stb;
    logic        watch_oe;
    logic        oe_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [7:0] d);
        exp_q.push_back({a, d});
    endtask

    // Driver tasks: all bus changes happen on the falling clk edge.
    task automatic qw();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_ctrl = 1'b0; qw();
        scl_i    = 1'b0; qw();
    endtask

    task automatic bus_restart();
        sda_ctrl = 1'b1; qw();
        scl_i    = 1'b1; qw();
        sda_ctrl = 1'b0; qw();
        scl_i    = 1'b0; qw();
    endtask

    task automatic bus_stop();
        sda_ctrl = 1'b0; qw();
        scl_i    = 1'b1; qw();
        sda_ctrl = 1'b1; qw();
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_ctrl = b; qw();
        scl_i    = 1'b1; qw();
        if (glitch) begin
            repeat (3) @(negedge clk);
            scl_i = 1'b0;
            @(negedge clk);
            scl_i = 1'b1;
        end
        qw();
        scl_i = 1'b0; qw();
    endtask

    task automatic ack_phase(input string name, input logic exp_ack);
        logic a;
        sda_ctrl = 1'b1; qw();
        scl_i    = 1'b1; qw();
        a = sda_line;
        qw();
        scl_i = 1'b0; qw();
        check(name, a, exp_ack);
    endtask

    task automatic write_byte(input string name, input logic [7:0] d, input logic exp_ack,
                              input logic glitch);
        for (int i = 7; i >= 0; i--) send_bit(d[i], glitch);
        ack_phase(name, exp_ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack_bit);
        for (int i = 7; i >= 0; i--) begin
            sda_ctrl = 1'b1; qw();
            scl_i    = 1'b1; qw();
            d[i] = sda_line;
            qw();
            scl_i = 1'b0; qw();
        end
        send_bit(ack_bit, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor: pops the expected write on every strobe.
    initial begin
        logic [12:0] e;
        prev_stb = 1'b0;
        chk_pend = 1'b0;
        chk_val  = 8'h00;
        oe_seen  = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_pend) begin
                check("rd_new_after_wr", rd_data, chk_val);
                chk_pend = 1'b0;
            end
            if (reg_wr_stb) begin
                check("stb_one_cycle", prev_stb, 1'b0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wr_stb: actual addr=%0h data=%0h expected no strobe",
                             reg_wr_addr, reg_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", reg_wr_addr, e[12:8]);
                    check("wr_data", reg_wr_data, e[7:0]);
                    if (rd_addr == e[12:8]) begin
                        check("rd_old_during_wr", rd_data, mdl[e[12:8]]);
                        chk_pend = 1'b1;
                        chk_val  = e[7:0];
                    end
                    mdl[e[12:8]] = e[7:0];
                end
            end
            prev_stb = reg_wr_stb;
            if (watch_oe && sda_oe) oe_seen = 1'b1;
        end
    end

    initial begin
        logic [7:0] rb;
        rst_n    = 1'b0;
        scl_i    = 1'b1;
        sda_ctrl = 1'b1;
        rd_addr  = 5'd0;
        watch_oe = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 8'h00;
        repeat (4) @(negedge clk);
        check("reset_sda_oe", sda_oe, 1'b0);
        check("reset_wr_stb", reg_wr_stb, 1'b0);
        check("reset_reg0", rd_data, 8'h00);
        rd_addr = 5'd31;
        @(negedge clk);
        check("reset_reg31", rd_data, 8'h00);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Burst write at pointer 2; reg 2 is watched for same-cycle old/new visibility.
        rd_addr = 5'd2;
        push_wr(5'd2, 8'hA5);
        push_wr(5'd3, 8'h5A);
        bus_start();
        write_byte("wr1_addr_ack", 8'h20, 1'b0, 1'b0);
        write_byte("wr1_ptr_ack",  8'h02, 1'b0, 1'b0);
        write_byte("wr1_d0_ack",   8'hA5, 1'b0, 1'b0);
        write_byte("wr1_d1_ack",   8'h5A, 1'b0, 1'b0);
        bus_stop();
        rd_addr = 5'd3;
        @(negedge clk);
        check("wr1_reg3", rd_data, 8'h5A);
        rd_addr = 5'd2;
        @(negedge clk);
        check("wr1_reg2", rd_data, 8'hA5);

        // Random read from reg 3 via repeated START.
        bus_start();
        write_byte("rd_addr_ack", 8'h20, 1'b0, 1'b0);
        write_byte("rd_ptr_ack",  8'h03, 1'b0, 1'b0);
        bus_restart();
        write_byte("rd_addr_r_ack", 8'h21, 1'b0, 1'b0);
        read_byte(rb, 1'b0);
        check("rd_byte0", rb, 8'h5A);
        read_byte(rb, 1'b1);
        check("rd_byte1", rb, 8'h00);
        repeat (8) @(negedge clk);
        check("rd_oe_after_nack", sda_oe, 1'b0);
        bus_stop();

        // Wrong device address: no ACK, no drive, no write.
        oe_seen  = 1'b0;
        watch_oe = 1'b1;
        bus_start();
        write_byte("bad_addr_nack", 8'h22, 1'b1, 1'b0);
        write_byte("bad_ptr_nack",  8'h02, 1'b1, 1'b0);
        write_byte("bad_data_nack", 8'h77, 1'b1, 1'b0);
        bus_stop();
        watch_oe = 1'b0;
        check("bad_oe_never", oe_seen, 1'b0);
        rd_addr = 5'd2;
        @(negedge clk);
        check("bad_reg2_kept", rd_data, 8'hA5);

        // Pointer wrap from 31 to 0.
        push_wr(5'd31, 8'h11);
        push_wr(5'd0,  8'h22);
        bus_start();
        write_byte("wrap_addr_ack", 8'h20, 1'b0, 1'b0);
        write_byte("wrap_ptr_ack",  8'h1F, 1'b0, 1'b0);
        write_byte("wrap_d0_ack",   8'h11, 1'b0, 1'b0);
        write_byte("wrap_d1_ack",   8'h22, 1'b0, 1'b0);
        bus_stop();
        rd_addr = 5'd31;
        @(negedge clk);
        check("wrap_reg31", rd_data, 8'h11);
        rd_addr = 5'd0;
        @(negedge clk);
        check("wrap_reg0", rd_data, 8'h22);

        // Reset during the 4th bit of a data byte (0xF0, that bit is 1 so SDA stays high).
        push_wr(5'd5, 8'h33);
        bus_start();
        write_byte("rst_addr_ack", 8'h20, 1'b0, 1'b0);
        write_byte("rst_ptr_ack",  8'h05, 1'b0, 1'b0);
        write_byte("rst_d0_ack",   8'h33, 1'b0, 1'b0);
        for (int i = 7; i >= 5; i--) send_bit(1'b1, 1'b0);
        sda_ctrl = 1'b1; qw();
        scl_i    = 1'b1;
        repeat (3) @(negedge clk);
        do_reset();
        repeat (2) @(negedge clk);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_wr_stb", reg_wr_stb, 1'b0);
        qw();
        scl_i = 1'b0; qw();
        for (int i = 3; i >= 0; i--) send_bit(1'b0, 1'b0);
        ack_phase("rst_rest_nack", 1'b1);
        write_byte("rst_next_nack", 8'h44, 1'b1, 1'b0);
        bus_stop();
        rd_addr = 5'd5;
        @(negedge clk);
        check("rst_reg5", rd_data, 8'h00);
        rd_addr = 5'd31;
        @(negedge clk);
        check("rst_reg31", rd_data, 8'h00);
        rd_addr = 5'd0;
        @(negedge clk);
        check("rst_reg0", rd_data, 8'h00);

        // Normal write after recovery.
        push_wr(5'd7, 8'h99);
        bus_start();
        write_byte("rec_addr_ack", 8'h20, 1'b0, 1'b0);
        write_byte("rec_ptr_ack",  8'h07, 1'b0, 1'b0);
        write_byte("rec_d0_ack",   8'h99, 1'b0, 1'b0);
        bus_stop();
        rd_addr = 5'd7;
        @(negedge clk);
        check("rec_reg7", rd_data, 8'h99);

`ifdef I2C_TARGET_GLITCH_FILTER_EN
        // 1-clk SCL low glitch during every high phase must not add bits.
        push_wr(5'd10, 8'h3C);
        bus_start();
        write_byte("gl_addr_ack", 8'h20, 1'b0, 1'b1);
        write_byte("gl_ptr_ack",  8'h0A, 1'b0, 1'b1);
        write_byte("gl_d0_ack",   8'h3C, 1'b0, 1'b1);
        bus_stop();
        rd_addr = 5'd10;
        @(negedge clk);
        check("gl_reg10", rd_data, 8'h3C);
`endif

        repeat (20) @(negedge clk);
        check("wr_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/i2c_target_regs.md
I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h10, the 7-bit I2C device address this block answers to.
REQ-002 SHALL have parameter NREGS, default 32, the register count; it SHALL be a power of two, from 2 to 256.
REQ-003 SHALL have parameter RESET_VAL, default 8'h00, the reset value of every register.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic runs on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port scl_i, input, 1 bit: raw SCL pin level.
REQ-007 SHALL have port sda_i, input, 1 bit: raw SDA pin level.
REQ-008 SHALL have port sda_oe, output, 1 bit: 1 pulls SDA low; the top level converts it to open drain.
REQ-009 SHALL have port reg_wr_stb, output, 1 bit: one-cycle pulse when a register is written over I2C.
REQ-010 SHALL have port reg_wr_addr, output, log2(NREGS) bits: index of the register just written; valid while reg_wr_stb is high.
REQ-011 SHALL have port reg_wr_data, output, 8 bits: value just written; valid while reg_wr_stb is high.
REQ-012 SHALL have port rd_addr, input, log2(NREGS) bits: fabric read index.
REQ-013 SHALL have port rd_data, output, 8 bits: combinational value of the register at rd_addr.

Function
REQ-014 SHALL pass scl_i and sda_i through 2-flop synchronizers, then detect SCL edges, START and STOP from the synchronized signals.
- START: SDA falls while SCL is high.
- STOP: SDA rises while SCL is high.
REQ-015 SHALL sample SDA at the synchronized SCL rising edge, and SHALL change sda_oe only within 1 clk after the synchronized SCL falling edge.
REQ-016 SHALL implement these states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK.
REQ-017 SHALL go from any state to ADDR on START, which includes repeated START, and SHALL clear the bit counter.
REQ-018 SHALL go from any state to IDLE on STOP, and SHALL release sda_oe on the same edge.
REQ-019 SHALL handle the address byte (ADDR state) as follows.
- After 8 bits, if bits[7:1] equal DEV_ADDR, go to ADDR_ACK and drive sda_oe=1 for the 9th SCL period.
- Otherwise go to IDLE with sda_oe=0.
REQ-020 SHALL leave ADDR_ACK to PTR when R/W=0.
REQ-021 SHALL leave ADDR_ACK to RDATA when R/W=1, with the first byte = reg[ptr].
REQ-022 SHALL, in PTR, load ptr from the low log2(NREGS) bits of the received byte, ACK it, then go to WDATA.
REQ-023 SHALL, in WDATA, write each received byte to reg[ptr] and pulse reg_wr_stb for exactly 1 clk with the pre-increment ptr; then ACK, increment ptr, and stay in the write loop.
REQ-024 SHALL, in RDATA, shift out MSB first; SDA high is sent by releasing the line, SDA low by asserting sda_oe.
REQ-025 SHALL, in RACK, sample the controller's bit.
- ACK (0): increment ptr, load the next byte, return to RDATA.
- NACK (1): release sda_oe and go to IDLE.
REQ-026 SHALL wrap ptr modulo NREGS; at NREGS-1 it increments to 0.
REQ-027 SHALL, if a fabric read and an I2C write hit the same register in the same cycle, return the old value on rd_data that cycle and the new value from the next cycle.
REQ-028 SHALL load the read byte for RDATA at the ACK-period falling edge, so a write in progress never changes a byte already being shifted.
REQ-029 SHALL require clk to be at least 16x the SCL frequency; behaviour below that ratio is undefined.
REQ-030 SHALL never stretch SCL.

Reset
REQ-031 SHALL, while rst_n=0 at a clk edge, set the following:
- state=IDLE, ptr=0, bit counter=0;
- sda_oe=0, reg_wr_stb=0;
- all registers=RESET_VAL;
- synchronizer flops=1 (bus idle).
REQ-032 SHALL, after reset is released in the middle of a transfer, ignore the bus until the next START.

Configuration
REQ-033 SHALL, when I2C_TARGET_GLITCH_FILTER_EN is defined, add a 3-sample majority filter on both synchronized lines after the synchronizers, adding 2 clk of latency.
REQ-034 SHALL, when I2C_TARGET_GLITCH_FILTER_EN is undefined, have no filter; the pin-to-edge latency is then 3 clk.

Structure
REQ-035 SHALL place the state enumeration and the I2C_ACK/I2C_NACK constants in the shared package i2c_pkg.
REQ-036 SHALL contain one sub-module, i2c_bus_monitor, which holds the synchronizers, the optional filter, and the SCL-edge/START/STOP pulse outputs.

Verification
REQ-037 SHALL cover this write: START, 0x20, 0x02, 0xA5, 0x5A, STOP -> ACK on all 4 bytes; reg_wr_stb with (2,0xA5) then (3,0x5A); rd_addr=3 gives 0x5A.
REQ-038 SHALL cover this random read: START, 0x20, 0x03, repeated START, 0x21, read 2 bytes with ACK then NACK -> returns 0x5A, then reg[4]=0x00; sda_oe=0 after the NACK.
REQ-039 SHALL cover a wrong address: START, 0x22, ... -> sda_oe stays 0 for the whole transfer; no reg_wr_stb.
REQ-040 SHALL cover pointer wrap: write ptr=0x1F with data 0x11, 0x22 -> reg[31]=0x11, reg[0]=0x22.
REQ-041 SHALL cover reset mid-byte: rst_n low during the 4th bit of a data byte -> registers=RESET_VAL, sda_oe=0, and the rest of that byte is ignored.
REQ-042 SHALL cover, with I2C_TARGET_GLITCH_FILTER_EN defined, a 1-clk low glitch on SCL while it is high -> no bit sampled; the transfer result is unchanged.
